receive_uart: RTL
=================

RECEIVE_UART -- requirements
Module: receive_uart

Interface
REQ-001 The module SHALL have parameter CLOCKS_PER_BIT, default 10, giving the clock cycles per serial bit; legal values are integers of 4 or more.
REQ-002 The module SHALL have port clock, input, 1 bit: system clock; all logic SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clock.
REQ-005 The module SHALL have port rxdata, output, 8 bits: last correctly framed byte.
REQ-006 The module SHALL have port rxvalid, output, 1 bit: level flag meaning rxdata holds an unconsumed byte.
REQ-007 The module SHALL have port rxack, input, 1 bit: consumer acknowledge; it clears rxvalid.
REQ-008 The module SHALL have port rxerror, output, 1 bit: one-cycle pulse on a framing error (stop bit sampled low).
REQ-009 The module SHALL have port rxoverrun, output, 1 bit: one-cycle pulse when a byte completes while rxvalid=1 and rxack=0.

Function
REQ-010 The module SHALL accept 8N1 frames: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-011 The module SHALL pass rx through a two-flop synchronizer; rx_s denotes the synchronized value, and only rx_s SHALL be used by the FSM.
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 In IDLE, on rx_s=0, the FSM SHALL enter START and load the counter with CLOCKS_PER_BIT/2-1 (integer division); the cycle of this transition is t0.
REQ-014 Every non-IDLE state SHALL decrement the counter each cycle and act only when the counter is 0.
REQ-015 START at counter 0 SHALL do the following: if rx_s=0, go to DATA with bit index 0 and counter CLOCKS_PER_BIT-1; if rx_s=1 (glitch), go to IDLE with no output activity.
REQ-016 DATA at counter 0 SHALL write rx_s into shift register bit [index] and reload the counter to CLOCKS_PER_BIT-1; after index 7 it SHALL go to STOP, otherwise it SHALL increment the index.
REQ-017 STOP at counter 0 with rx_s=1 SHALL load rxdata from the shift register, set rxvalid, and go to IDLE in the same cycle.
REQ-018 STOP at counter 0 with rx_s=0 SHALL pulse rxerror, leave rxdata and rxvalid unchanged, and go to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL go to IDLE in the first cycle rx_s=1; a line held low (break) SHALL produce exactly one rxerror.
REQ-020 For CLOCKS_PER_BIT=10, the stop bit SHALL be sampled at t0+95 and rxvalid SHALL read 1 from cycle t0+96.
REQ-021 rxack=1 with rxvalid=1 SHALL clear rxvalid on the next edge; rxack with rxvalid=0 SHALL be ignored.
REQ-022 When a byte completes in a cycle with rxack=1, rxvalid SHALL remain 1, rxdata SHALL take the new byte, and there SHALL be no overrun.
REQ-023 When a byte completes with rxvalid=1 and rxack=0, rxdata SHALL be overwritten with the new byte and rxoverrun SHALL pulse for one cycle.
REQ-024 rxdata SHALL change only on a good stop bit.

Reset
REQ-025 Reset SHALL set the FSM to IDLE, both synchronizer flops to 1, the shift register to 0, the counter and bit index to 0, rxdata to 8'h00, and rxvalid, rxerror and rxoverrun to 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no rxvalid, rxerror or rxoverrun pulse; after release the first byte received SHALL be taken only from a fresh start bit.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the frame constants DATA_BITS=8, START_LEVEL=0 and STOP_LEVEL=1, for reuse by the transmitter and testbenches.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff, with clock, asynchronous active-high reset (reset value 1), input d and output q.

Verification
REQ-029 With CLOCKS_PER_BIT=10, a frame carrying 0xA5 SHALL produce rxdata=0xA5, with rxvalid rising 96 cycles after t0 and rxerror=0.
REQ-030 A 3-cycle low glitch on an idle line SHALL produce no outputs, and a following frame carrying 0x3C SHALL be received correctly.
REQ-031 A frame carrying 0x55 with the stop bit driven 0 and the line then held low for 50 cycles SHALL produce one rxerror pulse, rxvalid=0 and rxdata unchanged; a later frame carrying 0x81 SHALL be received.
REQ-032 Frames carrying 0x11 then 0x22 with no rxack SHALL leave rxdata=0x22 and rxvalid=1 and produce one rxoverrun pulse; with rxack driven in the completion cycle of 0x22, there SHALL be no rxoverrun.
REQ-033 Reset asserted at the midpoint of bit 4 of a frame carrying 0xFF, then released, SHALL leave all outputs at reset values, and a following frame carrying 0x0F SHALL yield rxdata=0x0F.
REQ-034 A loopback from the team transmitter, run with equal CLOCKS_PER_BIT and all 256 byte values sent back to back, SHALL receive every byte with no error or overrun when rxack is driven each byte.

Source files
------------

// File: rtl/receive_uart_pkg.sv
// Shared UART frame definitions: receiver FSM encoding and 8N1 frame constants.
package receive_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Width of a down-counter able to hold cpb-1.
    function automatic int cnt_width(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/receive_uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous level; resets to the idle-high value.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second filters it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receive_uart.sv
// 8N1 UART receiver: mid-bit sampling, level-valid handshake, error/overrun pulses.
module receive_uart
    import receive_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    input  logic       rxack,
    output logic       rxerror,
    output logic       rxoverrun
);

    localparam int CW = cnt_width(CLOCKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    // Half a bit puts the start-bit check at its centre; whole bits from there on.
    localparam logic [CW-1:0] HALF_BIT = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [7:0]           rxdata_q;
    logic                 rxvalid_q;
    logic                 rxerror_q;
    logic                 rxoverrun_q;
    logic                 cnt_zero;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign cnt_zero = (cnt_q == '0);

    // Receive FSM with registered outputs; every non-idle state counts down and acts at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            rxdata_q    <= 8'h00;
            rxvalid_q   <= 1'b0;
            rxerror_q   <= 1'b0;
            rxoverrun_q <= 1'b0;
        end else begin
            rxerror_q   <= 1'b0;
            rxoverrun_q <= 1'b0;
            if (rxack && rxvalid_q)
                rxvalid_q <= 1'b0;
            if (state_q != ST_IDLE && !cnt_zero)
                cnt_q <= cnt_q - 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (rx_s == START_LEVEL) begin
                        state_q <= ST_START;
                        cnt_q   <= HALF_BIT;
                    end
                end
                ST_START: begin
                    if (cnt_zero) begin
                        if (rx_s == START_LEVEL) begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                            cnt_q   <= FULL_BIT;
                        end else begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        shreg_q[idx_q] <= rx_s;
                        cnt_q          <= FULL_BIT;
                        if (idx_q == LAST_IDX)
                            state_q <= ST_STOP;
                        else
                            idx_q <= idx_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_zero) begin
                        if (rx_s == STOP_LEVEL) begin
                            // An ack in this same cycle frees the slot, so no overrun.
                            rxdata_q    <= shreg_q;
                            rxvalid_q   <= 1'b1;
                            rxoverrun_q <= rxvalid_q && !rxack;
                            state_q     <= ST_IDLE;
                        end else begin
                            rxerror_q <= 1'b1;
                            state_q   <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    // Hold off until the line recovers so a break reports only once.
                    if (rx_s == STOP_LEVEL)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rxdata    = rxdata_q;
    assign rxvalid   = rxvalid_q;
    assign rxerror   = rxerror_q;
    assign rxoverrun = rxoverrun_q;

endmodule
